// File: rtl/regfile_pkg.sv
// Shared types and widths for the register-file writeback path.
package regfile_pkg;
  localparam int REG_ADDR_W   = 6;
  localparam int VEC_BANK_BIT = 5;
  localparam int SCL_W        = 32;
  localparam int VEC_W        = 128;
  localparam int NREGS        = 25;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [VEC_W-1:0]      data;
  } wb_req_t;
endpackage

// File: rtl/wb_skid_fifo.sv
// Small circular FIFO of writeback requests; exposes per-entry valid and
// destination index so the owner can build a pending-write scoreboard.
module wb_skid_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  wb_req_t                    push_req_i,
  input  logic                       pop_i,
  output wb_req_t                    head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [DEPTH-1:0]           ent_vld_o,
  output logic [DEPTH-1:0][4:0]      ent_idx_o
);
  localparam int PW = $clog2(DEPTH);

  wb_req_t         mem_q [DEPTH];
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]     count_q, count_d;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push_i) begin
      wr_d    = wr_q + PW'(1);
      count_d = count_d + (PW+1)'(1);
    end
    if (pop_i) begin
      rd_d    = rd_q + PW'(1);
      count_d = count_d - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= push_req_i;
  end

  // Entry j is live when its distance from the read pointer is below count.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      ent_vld_o[j] = {1'b0, PW'(j) - rd_q} < count_q;
      ent_idx_o[j] = mem_q[j].addr[4:0];
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges scalar and queued vector results onto the single register-file
// write port, with bounded vector starvation and a vector-pending scoreboard.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int VFIFO_DEPTH  = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int NREGS        = regfile_pkg::NREGS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [4:0]            s_addr,
  input  logic [SCL_W-1:0]      s_data,
  input  logic                  v_valid,
  output logic                  v_ready,
  input  logic [4:0]            v_addr,
  input  logic [VEC_W-1:0]      v_data,
  output logic                  we,
  output logic [REG_ADDR_W-1:0] waddr,
  output logic [VEC_W-1:0]      wdata,
  output logic [NREGS-1:0]      v_pending,
  output logic                  err_addr
);
  localparam int CW = $clog2(VFIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  function automatic logic idx_oob(input logic [4:0] idx);
    return int'(idx) >= NREGS;
  endfunction

  function automatic logic idx_writable(input logic [4:0] idx);
    return (idx != 5'd0) && !idx_oob(idx);
  endfunction

  wb_req_t                     head;
  logic [CW-1:0]               count;
  logic [VFIFO_DEPTH-1:0]      ent_vld;
  logic [VFIFO_DEPTH-1:0][4:0] ent_idx;

  logic                  we_q, we_d, err_q, err_d;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
  logic [VEC_W-1:0]      wdata_q, wdata_d;
  logic [SW-1:0]         starve_q, starve_d;

  logic fifo_ne, starve, s_issue, v_issue, v_push;

  assign fifo_ne = count != '0;
  assign starve  = (starve_q == SW'(STARVE_LIMIT)) && fifo_ne;
  assign s_ready = !rst && !starve;
  assign v_ready = !rst && (count < CW'(VFIFO_DEPTH));
  assign s_issue = s_valid && s_ready;
  assign v_issue = !rst && fifo_ne && (starve || !s_valid);
  assign v_push  = v_valid && v_ready;

  wb_skid_fifo #(.DEPTH(VFIFO_DEPTH)) u_vfifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (v_push),
    .push_req_i ({1'b1, v_addr, v_data}),
    .pop_i      (v_issue),
    .head_o     (head),
    .count_o    (count),
    .ent_vld_o  (ent_vld),
    .ent_idx_o  (ent_idx)
  );

  always_comb begin
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    starve_d = starve_q;
    if (s_issue) begin
      we_d    = idx_writable(s_addr);
      waddr_d = {1'b0, s_addr};
      wdata_d = {{(VEC_W-SCL_W){1'b0}}, s_data};
      err_d   = err_d | idx_oob(s_addr);
    end else if (v_issue) begin
      we_d    = idx_writable(head.addr[4:0]);
      waddr_d = head.addr;
      wdata_d = head.data;
    end
    if (v_push) err_d = err_d | idx_oob(v_addr);
    // The counter only measures how long a queued vector has been waiting.
    if (v_issue || !fifo_ne)
      starve_d = '0;
    else if (s_issue && starve_q != SW'(STARVE_LIMIT))
      starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      starve_q <= '0;
    end else begin
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    v_pending = '0;
    for (int i = 0; i < NREGS; i++) begin
      for (int j = 0; j < VFIFO_DEPTH; j++)
        if (ent_vld[j] && ent_idx[j] == 5'(i)) v_pending[i] = 1'b1;
      if (we_q && waddr_q[VEC_BANK_BIT] && waddr_q[4:0] == 5'(i)) v_pending[i] = 1'b1;
    end
  end

  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign err_addr = err_q;
endmodule
